fft_frame_arbiter: RTL
======================

Name: fft_frame_arbiter

Overview:
- Shares one 16-point FFT core between two sample streams (ch0, ch1), one whole frame at a time, with round-robin fairness.
- Sits between the two producers and the core's input push/stall interface.
- Also sits on the core's output push/stall interface, where it tags each result sample with the channel that owns its frame.
- Tracks frames in flight so results are always attributed in the order the frames were loaded.

Parameters:
- N_POINTS, 16, samples per frame and results per frame; counters are log2(N_POINTS) bits wide.
- DATA_W, 16, width of each real/imag component.
- TAG_DEPTH, 2, maximum frames outstanding (loading, in core, or unloading); depth of the channel-tag FIFO.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ch0_in_push  in  1  ch0 sample valid / frame request.
- ch0_in_real  in  DATA_W  ch0 sample real part.
- ch0_in_imag  in  DATA_W  ch0 sample imag part.
- ch0_in_stall  out  1  ch0 must hold its sample.
- ch1_in_push / ch1_in_real / ch1_in_imag / ch1_in_stall  same as ch0.
- core_in_push  out  1  sample to the FFT core.
- core_in_real  out  DATA_W  sample to the FFT core.
- core_in_imag  out  DATA_W  sample to the FFT core.
- core_in_stall  in  1  FFT core input stall.
- core_out_push  in  1  FFT core result valid.
- core_out_real  in  DATA_W  FFT core result real part.
- core_out_imag  in  DATA_W  FFT core result imag part.
- core_out_stall  out  1  stall to the FFT core; equals out_stall.
- out_push  out  1  tagged result valid.
- out_real  out  DATA_W  tagged result real part.
- out_imag  out  DATA_W  tagged result imag part.
- out_chan  out  1  owning channel of the current result.
- out_last  out  1  marks the final (N_POINTS-th) result of a frame.
- out_stall  in  1  downstream stall.
- busy_F  out  1  registered; high while state is LOAD.
- err_F  out  1  registered, sticky; result arrived with no frame outstanding.

Behaviour:
- Protocol: a producer keeps push asserted, data stable, while its stall is high. A sample transfers in any cycle where push=1 and stall=0.
- States: IDLE, LOAD. Reset gives IDLE, grant=0, rr_ptr=0, in_cnt=0, out_cnt=0, outstanding=0, tag FIFO empty, busy_F=0, err_F=0.
- IDLE:
  - both chX_in_stall=1; core_in_push=0.
  - If outstanding<TAG_DEPTH and any chX_in_push=1, grant the channel rr_ptr points to if it is requesting, else the other.
  - On grant, next cycle: state=LOAD, grant=X, rr_ptr=~X, tag X written to FIFO, outstanding+1.
  - If no request or outstanding==TAG_DEPTH, stay in IDLE.
- LOAD:
  - Granted channel: stall = core_in_stall. Other channel: stall=1.
  - core_in_push = granted push & ~core_in_stall; core_in_real/imag are the granted channel's data, combinational with zero latency.
  - Each transfer increments in_cnt.
  - On the N_POINTS-th transfer, in_cnt wraps to 0 and state goes to IDLE next cycle.
  - There is no back-to-back LOAD: the IDLE cycle between frames is mandatory. Minimum frame period is N_POINTS+1 cycles.
- Output path:
  - out_push = core_out_push; out_real/imag pass through combinationally; core_out_stall = out_stall.
  - out_chan = tag FIFO head.
  - out_last = (out_cnt==N_POINTS-1) & core_out_push.
  - Each core_out_push increments out_cnt. On out_last: out_cnt wraps, FIFO pops, outstanding-1.
- Simultaneous grant and final-result pop in the same cycle: outstanding unchanged; FIFO write and pop both occur.
- core_out_push while outstanding==0: err_F set and held until reset; out_chan=0; FIFO and counters unchanged.
- Only whole frames are granted; a producer dropping push mid-frame simply pauses LOAD.
- Reset mid-frame aborts everything immediately. The FFT core shares the same reset, so no partial frame survives.

Test Plan:
- Only ch0 pushes 16 samples, core never stalls → grant one cycle after request. core_in_push high for 16 consecutive cycles with data equal to ch0's. ch1_in_stall=1 throughout. busy_F falls after the 16th sample.
- Both channels request continuously, 4 frames → grant order ch0, ch1, ch0, ch1. One IDLE cycle between frames. out_chan sequence 0,1,0,1, with 16 results each and out_last on every 16th.
- Core holds results (core_out_push=0) while both request → after 2 frames are granted, no third grant. Both stalls stay 1 until the first frame's 16th result pops; the next grant follows one cycle later.
- core_in_stall toggled every other cycle during LOAD → exactly 16 transfers. in_cnt does not advance on stalled cycles. Producer data is held stable while stalled.
- core_out_push pulsed with nothing outstanding → err_F=1 the next cycle and stays 1; out_chan=0.
- reset asserted after 7 samples of a ch1 frame → all outputs go to reset values asynchronously. The next ch0 request is granted with rr_ptr=0 behaviour.

Source files
------------

// File: rtl/fft_frame_arbiter_if.sv
// Push/stall sample stream carrying one complex sample per transfer.
// A sample moves in any cycle where push=1 and stall=0; the sender holds
// push and data stable while stall is high.
//   master: drives push/re/im, receives stall
//   slave : receives push/re/im, drives stall
interface fft_frame_arbiter_if #(
  parameter int DATA_W = 16
);
  logic                     push;
  logic signed [DATA_W-1:0] re;
  logic signed [DATA_W-1:0] im;
  logic                     stall;

  modport master (output push, re, im, input stall);
  modport slave  (input push, re, im, output stall);
endinterface

// File: rtl/fft_frame_arbiter.sv
// Shares one N_POINTS-point FFT core between two sample streams, one whole
// frame at a time, with round-robin fairness. Results leaving the core are
// tagged with the channel that owns their frame, using a FIFO of channel
// tags written at grant time and popped on each frame's final result.
//
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   ch0, ch1    producer streams (slave side)
//   core_in     sample stream into the FFT core (master side)
//   core_out    result stream from the FFT core (slave side)
//   res         tagged result stream to downstream (master side)
//   out_chan    owning channel of the current result
//   out_last    final result of a frame
//   busy_F      registered, high while a frame is loading
//   err_F       registered, sticky; a result arrived with no frame outstanding
module fft_frame_arbiter #(
  parameter int N_POINTS  = 16,
  parameter int DATA_W    = 16,
  parameter int TAG_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  fft_frame_arbiter_if.slave   ch0,
  fft_frame_arbiter_if.slave   ch1,
  fft_frame_arbiter_if.master  core_in,
  fft_frame_arbiter_if.slave   core_out,
  fft_frame_arbiter_if.master  res,
  output logic                 out_chan,
  output logic                 out_last,
  output logic                 busy_F,
  output logic                 err_F
);

  localparam int CNT_W = $clog2(N_POINTS);
  localparam int OCC_W = $clog2(TAG_DEPTH + 1);
  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_POINTS - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(TAG_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(TAG_DEPTH - 1);

  typedef enum logic {S_IDLE, S_LOAD} state_t;

  state_t                   state_q, state_d;
  logic                     grant_q;
  logic                     rr_ptr_q;
  logic [CNT_W-1:0]         in_cnt_q;
  logic [CNT_W-1:0]         out_cnt_q;
  logic [OCC_W-1:0]         occ_q;
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [PTR_W-1:0]         rd_ptr_q;
  logic                     err_q;
  logic                     tag_mem [TAG_DEPTH];

  logic                     req_any;
  logic                     grant_sel;
  logic                     grant_fire;
  logic                     core_push_c;
  logic                     load_done;
  logic                     have_frame;
  logic                     out_xfer;
  logic                     pop;
  logic signed [DATA_W-1:0] sel_re;
  logic signed [DATA_W-1:0] sel_im;

  // Arbitration: the channel rr_ptr points to wins if it is requesting,
  // otherwise the other one (only meaningful when req_any is set).
  assign req_any    = ch0.push | ch1.push;
  assign grant_sel  = rr_ptr_q ? ch1.push : ~ch0.push;
  assign grant_fire = (state_q == S_IDLE) & req_any & (occ_q < OCC_FULL);

  assign load_done  = core_push_c & (in_cnt_q == CNT_LAST);

  // Results only advance the frame bookkeeping when they actually transfer
  // and belong to a known frame; stray results leave counters and FIFO alone.
  assign have_frame = (occ_q != '0);
  assign out_xfer   = core_out.push & ~res.stall & have_frame;
  assign pop        = out_xfer & (out_cnt_q == CNT_LAST);

  // ---- state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---- next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_fire) state_d = S_LOAD;
      S_LOAD:  if (load_done)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---- output logic (input side)
  always_comb begin
    ch0.stall   = 1'b1;
    ch1.stall   = 1'b1;
    core_push_c = 1'b0;
    sel_re      = grant_q ? ch1.re : ch0.re;
    sel_im      = grant_q ? ch1.im : ch0.im;
    if (state_q == S_LOAD) begin
      if (grant_q) ch1.stall = core_in.stall;
      else         ch0.stall = core_in.stall;
      core_push_c = (grant_q ? ch1.push : ch0.push) & ~core_in.stall;
    end
  end

  assign core_in.push = core_push_c;
  assign core_in.re   = sel_re;
  assign core_in.im   = sel_im;

  // ---- output side: results pass straight through, tagged from the FIFO head
  assign res.push       = core_out.push;
  assign res.re         = core_out.re;
  assign res.im         = core_out.im;
  assign core_out.stall = res.stall;
  assign out_chan       = have_frame ? tag_mem[rd_ptr_q] : 1'b0;
  assign out_last       = (out_cnt_q == CNT_LAST) & core_out.push;

  assign busy_F = (state_q == S_LOAD);
  assign err_F  = err_q;

  // ---- control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q   <= 1'b0;
      rr_ptr_q  <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      occ_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (grant_fire) begin
        grant_q  <= grant_sel;
        rr_ptr_q <= ~grant_sel;
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end

      if (core_push_c)
        in_cnt_q <= load_done ? '0 : in_cnt_q + 1'b1;

      if (out_xfer)
        out_cnt_q <= pop ? '0 : out_cnt_q + 1'b1;

      if (pop)
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;

      // A grant and a final-result pop in the same cycle cancel out.
      case ({grant_fire, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase

      if (core_out.push & ~have_frame)
        err_q <= 1'b1;
    end
  end

  // ---- tag storage (contents are only read while a frame is outstanding)
  always_ff @(posedge clk) begin
    if (grant_fire)
      tag_mem[wr_ptr_q] <= grant_sel;
  end

endmodule
